dmem_arbiter: RTL

Arbiter and access sequencer in front of `data_mem`, sharing its single word-addressed port between the scalar load/store stage and the vector load/store unit. Scalar requests are single-word accesses; vector requests are strided bursts of up to `MAX_VL` elements that the block expands into one memory access per cycle. It drives `mem_addr`, `mem_write_data`, `mem_write_en` and `stg_en`, and consumes the memory's registered `mem_data`.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/vec_addr_gen.sv | 37 +++
 rtl/dmem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter
// Ports: none (package).
package dmem_pkg;
  localparam int MAX_VL_DEF = 8;
  localparam int VL_W_DEF = 4;
  localparam int ELEM_W = 32;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t VEC_RUN = 2'd1;
  localparam state_t VEC_DRAIN = 2'd2;
endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: strided element address and index generator for vector bursts
// Ports: load latches base/stride/vl and preloads element 1; step advances one element;
//        addr/idx describe the element to issue, last flags the final element.
module vec_addr_gen import dmem_pkg::*; #(
  parameter int VL_W = VL_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [31:0]     base,
  input  logic [31:0]     stride,
  input  logic [VL_W-1:0] vl,
  output logic [31:0]     addr,
  output logic [VL_W-1:0] idx,
  output logic            last
);
  logic [31:0] stride_q;
  logic [VL_W-1:0] vl_q;
  // element 0 is issued straight from base in the accept cycle, so load primes element 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      idx <= '0;
      stride_q <= '0;
      vl_q <= '0;
    end else if (load) begin
      addr <= base + stride;
      idx <= VL_W'(1);
      stride_q <= stride;
      vl_q <= vl;
    end else if (step) begin
      addr <= addr + stride_q;
      idx <= idx + 1'b1;
    end
  assign last = idx == vl_q - 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data_mem port between scalar accesses and strided vector bursts
// Ports: s_* scalar request/grant/read-return; v_* vector burst request/status/load data;
//        mem_* / stg_en drive data_mem, mem_data is its registered read data.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int MAX_VL = MAX_VL_DEF,
  parameter int VL_W = VL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_req,
  input  logic                     s_we,
  input  logic [31:0]              s_addr,
  input  logic [31:0]              s_wdata,
  output logic                     s_gnt,
  output logic                     s_rvalid,
  output logic [31:0]              s_rdata,
  input  logic                     v_req,
  input  logic                     v_we,
  input  logic [31:0]              v_base,
  input  logic [31:0]              v_stride,
  input  logic [VL_W-1:0]          v_vl,
  input  logic [ELEM_W*MAX_VL-1:0] v_wdata,
  output logic                     v_busy,
  output logic                     v_done,
  output logic [ELEM_W*MAX_VL-1:0] v_rdata,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_write_data,
  output logic                     mem_write_en,
  output logic                     stg_en,
  input  logic [31:0]              mem_data
);
  state_t state, state_nx;
  logic last_vec, we_q, cap_en, g_last;
  logic idle, run, grant_s, grant_v, v_iss;
  logic [ELEM_W*MAX_VL-1:0] wd_q;
  logic [VL_W-1:0] vl_c, g_idx, cap_idx;
  logic [31:0] g_addr, run_wd;
  assign vl_c = v_vl > VL_W'(MAX_VL) ? VL_W'(MAX_VL) : v_vl;
  // rst gates the combinational grant path so every output reads zero while reset is held
  assign idle = state == IDLE && !rst;
  assign run = state == VEC_RUN && !rst;
  assign grant_s = idle && s_req && (!v_req || last_vec);
  assign grant_v = idle && v_req && (!s_req || !last_vec);
  assign v_iss = grant_v && vl_c != '0;
  assign run_wd = wd_q[ELEM_W*g_idx +: ELEM_W];
  assign s_gnt = grant_s;
  assign stg_en = grant_s || v_iss || run;
  assign mem_write_en = grant_s ? s_we : v_iss ? v_we : run && we_q;
  assign mem_addr = grant_s ? s_addr : v_iss ? v_base : run ? g_addr : '0;
  assign mem_write_data = grant_s ? s_wdata : v_iss ? v_wdata[ELEM_W-1:0] : run ? run_wd : '0;
  assign v_busy = state != IDLE;
  assign v_done = state == VEC_DRAIN;
  assign s_rdata = s_rvalid ? mem_data : '0;
  always_comb
    state_nx = grant_v ? (vl_c <= VL_W'(1) ? VEC_DRAIN : VEC_RUN) : run ? (g_last ? VEC_DRAIN : VEC_RUN) : IDLE;
  vec_addr_gen #(.VL_W(VL_W)) u_gen (
    .clk(clk),
    .rst(rst),
    .load(grant_v),
    .step(run),
    .base(v_base),
    .stride(v_stride),
    .vl(vl_c),
    .addr(g_addr),
    .idx(g_idx),
    .last(g_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_vec <= 1'b1;
      we_q <= 1'b0;
      wd_q <= '0;
      s_rvalid <= 1'b0;
      cap_en <= 1'b0;
      cap_idx <= '0;
      v_rdata <= '0;
    end else begin
      state <= state_nx;
      s_rvalid <= grant_s && !s_we;
      // the element issued this cycle returns on mem_data next cycle
      cap_en <= (v_iss && !v_we) || (run && !we_q);
      cap_idx <= run ? g_idx : '0;
      if (grant_s || grant_v) last_vec <= grant_v;
      if (grant_v) begin
        we_q <= v_we;
        wd_q <= v_wdata;
      end
      if (cap_en) v_rdata[ELEM_W*cap_idx +: ELEM_W] <= mem_data;
    end
endmodule
